// File: rtl/fft_pingpong_ram_if.sv
// Sample stream bundle for the FFT ping-pong frame buffer.
// ED stalls both sides; DO_VLD qualifies DO and RDY flags word 0 of a frame (no backpressure).
interface fft_pingpong_ram_if #(
  parameter int NB = 16
);
  logic          ED;
  logic          START;
  logic          MODE;
  logic [NB-1:0] DI;
  logic [NB-1:0] DO;
  logic          DO_VLD;
  logic          RDY;

  modport master (
    output ED, START, MODE, DI,
    input  DO, DO_VLD, RDY
  );

  modport slave (
    input  ED, START, MODE, DI,
    output DO, DO_VLD, RDY
  );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame buffer: frames are written in natural order into one bank while the
// previous frame is read from the other in natural or bit-reversed order.
module fft_pingpong_ram #(
  parameter int NB = 16,
  parameter int AW = 6
) (
  input  logic                CLK,
  input  logic                RSTn,
  fft_pingpong_ram_if.slave   bus
);
  localparam int N = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [NB-1:0] mem [0:2*N-1];

  logic [AW-1:0] wcnt, rcnt, raddr, raddr_q, waddr;
  logic          wbank, wr_act, wr_en, frame_done;
  logic          rbank, rd_act, rmode;
  logic          rbank_q, vld_q, first_q;
  logic [NB-1:0] do_q;
  logic          do_vld_q, rdy_q;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  always_comb begin
    wr_en      = bus.ED & (bus.START | wr_act);
    waddr      = bus.START ? '0 : wcnt;
    // A START on the last sample aborts the frame instead of completing it.
    frame_done = bus.ED & ~bus.START & wr_act & (wcnt == LAST);
    raddr      = rmode ? bitrev(rcnt) : rcnt;
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[{wbank, waddr}] <= bus.DI;
  end

  // Write side: sample counter and bank select.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wcnt   <= '0;
      wbank  <= 1'b0;
      wr_act <= 1'b0;
    end else if (bus.ED) begin
      if (bus.START) begin
        wcnt   <= AW'(1);
        wr_act <= 1'b1;
      end else if (wr_act) begin
        wcnt <= wcnt + 1'b1;
        if (frame_done) wbank <= ~wbank;
      end
    end
  end

  // Read stage 0: address generation, reloaded whenever a frame completes.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rcnt   <= '0;
      rd_act <= 1'b0;
      rbank  <= 1'b0;
      rmode  <= 1'b0;
    end else if (bus.ED) begin
      if (frame_done) begin
        rbank  <= wbank;
        rcnt   <= '0;
        rd_act <= 1'b1;
        rmode  <= bus.MODE;
      end else if (rd_act) begin
        rcnt <= rcnt + 1'b1;
        if (rcnt == LAST) rd_act <= 1'b0;
      end
    end
  end

  // Stages 1 and 2; the bank travels with the address because rbank flips under the last word.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      raddr_q  <= '0;
      rbank_q  <= 1'b0;
      vld_q    <= 1'b0;
      first_q  <= 1'b0;
      do_q     <= '0;
      do_vld_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else if (bus.ED) begin
      raddr_q  <= raddr;
      rbank_q  <= rbank;
      vld_q    <= rd_act;
      first_q  <= rd_act & (rcnt == '0);
      do_vld_q <= vld_q;
      rdy_q    <= first_q;
      if (vld_q) do_q <= mem[{rbank_q, raddr_q}];
    end
  end

  assign bus.DO     = do_q;
  assign bus.DO_VLD = do_vld_q;
  assign bus.RDY    = rdy_q;
endmodule
